pipeline_trace_capture: RTL and testbench
=========================================

// Module: pipeline_trace_capture
// PURPOSE
//  Consumer end of the pipeline datapath debug interface: watches the WB-stage retire stream
//  (instr_wb, alu_result_wb) plus MEM-stage control-flow flags, and on a programmable trigger
//  buffers retired instructions in a FIFO. Entries are drained by a valid/ready reader (bench, UART bridge).
// PARAMETERS
//  DEPTH      16  FIFO entries; power of two, >= 2
//  POST_CNT   8   retires captured after trigger before DONE; 1..255
//  TS_W       16  timestamp width (used only with TRACE_TIMESTAMP_EN)
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      async reset, active-high
//  wb_valid       in   1      non-bubble instruction retires in WB this cycle
//  instr_wb       in   32     retiring instruction word
//  alu_result_wb  in   32     retiring ALU result
//  Branch_mem     in   1      branch instruction in MEM
//  Jump_mem       in   1      jump instruction in MEM
//  ifbranch       in   1      branch condition true (taken) in MEM
//  arm            in   1      pulse: IDLE/DONE -> ARMED
//  abort          in   1      pulse: any state -> IDLE, FIFO contents kept
//  flush          in   1      pulse: empty FIFO, clear overflow
//  trig_mode      in   2      0 immediate, 1 taken branch, 2 jump, 3 taken branch or jump
//  rd_valid       out  1      FIFO non-empty
//  rd_ready       in   1      reader accepts head entry
//  rd_data        out  64(+TS_W)  {[TS], instr, alu_result}; instr in [63:32], alu in [31:0]
//  state          out  2      IDLE=0 ARMED=1 CAPTURE=2 DONE=3
//  overflow       out  1      sticky: a capture push was dropped (FIFO full)
//  level          out  clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, rd_valid=0, rd_data=0, overflow=0, level=0, post counter=0, TS=0.
//  IDLE: no pushes; arm -> ARMED.
//  ARMED: trig = mode0: wb_valid; mode1: Branch_mem&ifbranch; mode2: Jump_mem; mode3: mode1|mode2.
//   On trig -> CAPTURE; if wb_valid same cycle, that retire is entry 0 and counts toward POST_CNT.
//  CAPTURE: every wb_valid cycle is a push attempt and increments post counter; at the attempt making
//   count==POST_CNT, next state DONE. Further triggers ignored.
//  DONE: no pushes; arm -> ARMED (clears post counter and overflow, FIFO untouched).
//  abort has priority over arm and trig; flush acts in any state, independent of FSM.
//  FIFO: show-ahead; rd_data = head entry, rd_valid = level!=0; pop when rd_valid&rd_ready.
//   Push latency 1: entry pushed at edge N visible on rd_data after edge N if FIFO was empty.
//   Full and no pop: push dropped, overflow<=1, post counter still increments.
//   Full with pop same cycle: push accepted, level unchanged. Empty with rd_ready: no effect.
//   flush same cycle as push: flush wins, push discarded, level=0.
//   Pointers wrap modulo DEPTH; level saturates never (bounded by design).
//  Reset mid-capture: all state lost, returns to reset values asynchronously.
// CONFIGURATION
//  TRACE_TIMESTAMP_EN defined: free-running TS_W-bit cycle counter (wraps), sampled at push, prepended
//   as rd_data[63+TS_W:64]. Undefined: no counter, rd_data is exactly 64 bits.
// STRUCTURE
//  trace_pkg: state encoding constants, trig_mode codes, field offsets INSTR_LSB=32, ALU_LSB=0.
//  Sub-module trace_fifo (parameterised width/depth, show-ahead, level output); FSM + trigger in top.
// TESTING
//  1 mode0, arm, 10 retires (instr 0x20010001+i) -> first 8 captured in order, DONE, rd drains 8, rd_valid=0.
//  2 mode1, Branch_mem=1 ifbranch=0 -> stays ARMED; then ifbranch=1 with wb_valid -> CAPTURE, entry0=that retire.
//  3 DEPTH=4, POST_CNT=8, rd_ready=0 -> level=4, overflow=1, DONE after 8 attempts; arm clears overflow.
//  4 full FIFO, push+pop same cycle -> level stays 4, new entry appears last in read order.
//  5 abort during CAPTURE -> IDLE, FIFO retained; flush with simultaneous push -> level=0.
//  6 TRACE_TIMESTAMP_EN, rst then retires at cycles 3,5 -> TS fields 3,5; rst asserted mid-capture -> all reset values.

Source files
------------

// File: rtl/pipeline_trace_capture_pkg.sv
// Shared definitions for the pipeline trace capture block.
//   - FSM state encoding (also the value driven on the 'state' port)
//   - trig_mode codes and the trigger decode helper
//   - rd_data field offsets and base entry width
// Optional feature macro: TRACE_TIMESTAMP_EN (adds a timestamp field above the 64-bit entry).
package pipeline_trace_capture_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } trace_state_e;

  localparam logic [1:0] TRIG_IMMEDIATE  = 2'd0;
  localparam logic [1:0] TRIG_BRANCH     = 2'd1;
  localparam logic [1:0] TRIG_JUMP       = 2'd2;
  localparam logic [1:0] TRIG_BR_OR_JUMP = 2'd3;

  localparam int unsigned INSTR_LSB = 32;
  localparam int unsigned ALU_LSB   = 0;
  localparam int unsigned BASE_W    = 64;

`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  // Trigger condition seen while ARMED.
  function automatic logic trig_hit(input logic [1:0] mode, input logic wb_valid,
                                    input logic branch, input logic jump,
                                    input logic taken);
    logic hit;
    hit = 1'b0;
    case (mode)
      TRIG_IMMEDIATE:  hit = wb_valid;
      TRIG_BRANCH:     hit = branch & taken;
      TRIG_JUMP:       hit = jump;
      TRIG_BR_OR_JUMP: hit = (branch & taken) | jump;
      default:         hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pipeline_trace_capture_if.sv
// Retire-stream and trace read-port bundle.
//   master: pipeline/reader side (drives retire stream and rd_ready)
//   slave : capture block (drives rd_valid, rd_data)
// DATA_W is 64, or 64 + TS_W when TRACE_TIMESTAMP_EN is defined.
interface pipeline_trace_capture_if #(
  parameter int unsigned DATA_W = 64
);
  logic              wb_valid;
  logic [31:0]       instr_wb;
  logic [31:0]       alu_result_wb;
  logic              Branch_mem;
  logic              Jump_mem;
  logic              ifbranch;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wb_valid, instr_wb, alu_result_wb, Branch_mem, Jump_mem, ifbranch, rd_ready,
    input  rd_valid, rd_data
  );

  modport slave (
    input  wb_valid, instr_wb, alu_result_wb, Branch_mem, Jump_mem, ifbranch, rd_ready,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/pipeline_trace_capture_fifo.sv
// Show-ahead FIFO for trace entries.
//   clk, rst   : clock, async active-high reset
//   push       : write request (dropped when full unless a pop happens the same cycle)
//   push_data  : entry to write
//   pop_req    : reader ready; pops only when non-empty
//   flush      : empties the FIFO, overrides a simultaneous push
//   head       : current head entry (zero when empty)
//   not_empty  : head is valid
//   full       : occupancy == DEPTH
//   level      : occupancy
module pipeline_trace_capture_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_req,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     not_empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             pop, wr_en;

  assign not_empty = count_q != '0;
  assign full      = count_q == (PW+1)'(DEPTH);
  assign pop       = pop_req & not_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en     = push & (~full | pop) & ~flush;
  assign head      = not_empty ? mem[rd_ptr_q] : '0;
  assign level     = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + {{PW{1'b0}}, wr_en} - {{PW{1'b0}}, pop};
    end
  end

  // Storage needs no reset: head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pipeline_trace_capture.sv
// Trace capture of the WB-stage retire stream.
// An arm pulse moves IDLE/DONE -> ARMED; the selected trigger moves ARMED -> CAPTURE, after which
// every retire is pushed into a show-ahead FIFO until POST_CNT retires have been attempted (DONE).
//   clk, rst   : clock, async active-high reset
//   bus        : retire stream + valid/ready read port (slave modport)
//   arm, abort, flush : control pulses (abort beats arm/trigger; flush is FSM-independent)
//   trig_mode  : 0 immediate, 1 taken branch, 2 jump, 3 taken branch or jump
//   state      : IDLE=0 ARMED=1 CAPTURE=2 DONE=3
//   overflow   : sticky, a capture push was dropped on a full FIFO
//   level      : FIFO occupancy
// Optional: TRACE_TIMESTAMP_EN adds a free-running TS_W-bit counter sampled into rd_data[63+TS_W:64].
module pipeline_trace_capture
  import pipeline_trace_capture_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned POST_CNT = 8,
  parameter int unsigned TS_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_trace_capture_if.slave bus,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   flush,
  input  logic [1:0]             trig_mode,
  output logic [1:0]             state,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);
  localparam int unsigned DATA_W = BASE_W + (TS_EN ? TS_W : 0);

  trace_state_e      state_q;
  logic [7:0]        post_q;
  logic              overflow_q;
  logic              trig, push_try, fifo_full, fifo_pop, drop, last;
  logic [7:0]        post_next;
  logic [DATA_W-1:0] push_data;

  assign trig      = trig_hit(trig_mode, bus.wb_valid, bus.Branch_mem, bus.Jump_mem,
                              bus.ifbranch);
  // The triggering retire itself is entry 0.
  assign push_try  = bus.wb_valid & ~abort &
                     ((state_q == StCapture) | ((state_q == StArmed) & trig));
  assign post_next = post_q + 8'd1;
  assign last      = post_next == 8'(POST_CNT);
  assign fifo_pop  = bus.rd_ready & bus.rd_valid;
  assign drop      = push_try & fifo_full & ~fifo_pop & ~flush;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + TS_W'(1);
  end

  assign push_data = {ts_q, bus.instr_wb, bus.alu_result_wb};
`else
  assign push_data = {bus.instr_wb, bus.alu_result_wb};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      post_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (flush)     overflow_q <= 1'b0;
      else if (drop) overflow_q <= 1'b1;

      if (abort) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            if (arm) begin
              state_q    <= StArmed;
              post_q     <= '0;
              overflow_q <= 1'b0;
            end
          end
          StArmed: begin
            if (trig) begin
              state_q <= StCapture;
              if (bus.wb_valid) begin
                post_q <= post_next;
                if (last) state_q <= StDone;
              end
            end
          end
          StCapture: begin
            if (bus.wb_valid) begin
              post_q <= post_next;
              if (last) state_q <= StDone;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  pipeline_trace_capture_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_try),
    .push_data (push_data),
    .pop_req   (bus.rd_ready),
    .flush     (flush),
    .head      (bus.rd_data),
    .not_empty (bus.rd_valid),
    .full      (fifo_full),
    .level     (level)
  );

  assign state    = state_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pipeline_trace_capture.sv
module tb_pipeline_trace_capture;
  import pipeline_trace_capture_pkg::*;

  localparam int unsigned TS_W = 16;
  localparam int unsigned DW   = BASE_W + (TS_EN ? TS_W : 0);

  logic clk, rst;
  logic arm, abort, flush;
  logic [1:0] mode;
  logic wb_valid, br, jmp, ifb, rdy;
  logic [31:0] instr;

  logic [1:0] state_a, state_b;
  logic       ovf_a, ovf_b;
  logic [4:0] level_a;
  logic [2:0] level_b;

  pipeline_trace_capture_if #(.DATA_W(DW)) bus_a ();
  pipeline_trace_capture_if #(.DATA_W(DW)) bus_b ();

  assign bus_a.wb_valid = wb_valid;  assign bus_b.wb_valid = wb_valid;
  assign bus_a.instr_wb = instr;     assign bus_b.instr_wb = instr;
  assign bus_a.alu_result_wb = ~instr;
  assign bus_b.alu_result_wb = ~instr;
  assign bus_a.Branch_mem = br;      assign bus_b.Branch_mem = br;
  assign bus_a.Jump_mem = jmp;       assign bus_b.Jump_mem = jmp;
  assign bus_a.ifbranch = ifb;       assign bus_b.ifbranch = ifb;
  assign bus_a.rd_ready = rdy;       assign bus_b.rd_ready = rdy;

  pipeline_trace_capture #(.DEPTH(16), .POST_CNT(8), .TS_W(TS_W)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .arm(arm), .abort(abort), .flush(flush),
    .trig_mode(mode), .state(state_a), .overflow(ovf_a), .level(level_a)
  );

  pipeline_trace_capture #(.DEPTH(4), .POST_CNT(8), .TS_W(TS_W)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .arm(arm), .abort(abort), .flush(flush),
    .trig_mode(mode), .state(state_b), .overflow(ovf_b), .level(level_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ent(input logic [31:0] i);
    return {i, ~i};
  endfunction

  typedef struct {
    logic        arm, abort, flush;
    logic [1:0]  mode;
    logic        wb, br, jmp, ifb, rdy;
    logic [31:0] instr;
    logic [1:0]  e_state;
    int          e_level;
    logic [31:0] e_head;
  } vec_t;

  function automatic vec_t mk(input logic a, input logic ab, input logic fl, input logic [1:0] md,
                              input logic w, input logic b, input logic j, input logic t,
                              input logic r, input logic [31:0] ins, input logic [1:0] es,
                              input int el, input logic [31:0] eh);
    vec_t v;
    v.arm = a; v.abort = ab; v.flush = fl; v.mode = md;
    v.wb = w; v.br = b; v.jmp = j; v.ifb = t; v.rdy = r; v.instr = ins;
    v.e_state = es; v.e_level = el; v.e_head = eh;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    //          arm ab fl md wb br jp if rd instr          st lvl head
    tbl[0]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0,         1, 0, 32'h0);
    tbl[1]  = mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 32'hA000_0001, 1, 0, 32'h0);
    tbl[2]  = mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 32'hA000_0002, 1, 0, 32'h0);
    tbl[3]  = mk(0, 0, 0, 1, 1, 1, 0, 1, 0, 32'hA000_0003, 2, 1, 32'hA000_0003);
    tbl[4]  = mk(0, 0, 0, 1, 1, 1, 0, 1, 0, 32'hA000_0004, 2, 2, 32'hA000_0003);
    tbl[5]  = mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 32'hA000_0005, 0, 2, 32'hA000_0003);
    tbl[6]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 32'hA000_0006, 0, 2, 32'hA000_0003);
    tbl[7]  = mk(1, 0, 0, 2, 0, 0, 0, 0, 0, 32'h0,         1, 2, 32'hA000_0003);
    tbl[8]  = mk(0, 0, 0, 2, 1, 0, 0, 0, 0, 32'hA000_0008, 1, 2, 32'hA000_0003);
    tbl[9]  = mk(0, 0, 0, 2, 0, 0, 1, 0, 0, 32'h0,         2, 2, 32'hA000_0003);
    tbl[10] = mk(0, 0, 1, 2, 1, 0, 0, 0, 0, 32'hA000_000A, 2, 0, 32'h0);
    tbl[11] = mk(0, 0, 0, 2, 1, 0, 0, 0, 1, 32'hA000_000B, 2, 1, 32'hA000_000B);
    tbl[12] = mk(0, 0, 0, 2, 0, 0, 0, 0, 1, 32'h0,         2, 0, 32'h0);
    tbl[13] = mk(0, 1, 0, 2, 0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0);
    tbl[14] = mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 32'h0,         1, 0, 32'h0);
    tbl[15] = mk(0, 0, 0, 3, 0, 1, 0, 1, 0, 32'h0,         2, 0, 32'h0);
    tbl[16] = mk(0, 1, 0, 3, 0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0);

    rst = 1'b1;
    arm = 0; abort = 0; flush = 0; mode = 0;
    wb_valid = 0; br = 0; jmp = 0; ifb = 0; rdy = 0; instr = '0;
    step(); step();
    chk("rst_state", 96'(state_a), 96'(0));
    chk("rst_level", 96'(level_a), 96'(0));
    chk("rst_ovf", 96'(ovf_a), 96'(0));
    chk("rst_rd_valid", 96'(bus_a.rd_valid), 96'(0));
    chk("rst_rd_data", 96'(bus_a.rd_data), 96'(0));
    rst = 1'b0;

    // Table: trigger modes, abort retention, flush vs push, empty read.
    for (int k = 0; k < 17; k++) begin
      arm = tbl[k].arm; abort = tbl[k].abort; flush = tbl[k].flush; mode = tbl[k].mode;
      wb_valid = tbl[k].wb; br = tbl[k].br; jmp = tbl[k].jmp; ifb = tbl[k].ifb;
      rdy = tbl[k].rdy; instr = tbl[k].instr;
      step();
      chk($sformatf("vec%0d_state", k), 96'(state_a), 96'(tbl[k].e_state));
      chk($sformatf("vec%0d_level", k), 96'(level_a), 96'(tbl[k].e_level));
      chk($sformatf("vec%0d_head", k), 96'(bus_a.rd_data[63:0]),
          96'(tbl[k].e_level != 0 ? ent(tbl[k].e_head) : 64'h0));
    end
    arm = 0; abort = 0; flush = 0; wb_valid = 0; br = 0; jmp = 0; ifb = 0; rdy = 0;

    // Immediate capture of 10 retires: A keeps 8, B (depth 4) overflows.
    flush = 1; step(); flush = 0;
    mode = 0; arm = 1; step(); arm = 0;
    chk("arm_a", 96'(state_a), 96'(1));
    chk("arm_b", 96'(state_b), 96'(1));
    for (int i = 0; i < 10; i++) begin
      wb_valid = 1; instr = 32'h2001_0001 + 32'(i);
      step();
      if (i == 6) chk("cap_before_last", 96'(state_a), 96'(2));
      if (i == 7) begin
        chk("done_a", 96'(state_a), 96'(3));
        chk("done_b", 96'(state_b), 96'(3));
      end
    end
    wb_valid = 0;
    chk("lvl8_a", 96'(level_a), 96'(8));
    chk("ovf0_a", 96'(ovf_a), 96'(0));
    chk("lvl4_b", 96'(level_b), 96'(4));
    chk("ovf1_b", 96'(ovf_b), 96'(1));
    rdy = 1;
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("drain_a%0d", j), 96'(bus_a.rd_data[63:0]), 96'(ent(32'h2001_0001 + 32'(j))));
      if (j < 4)
        chk($sformatf("drain_b%0d", j), 96'(bus_b.rd_data[63:0]),
            96'(ent(32'h2001_0001 + 32'(j))));
      step();
    end
    rdy = 0;
    chk("empty_a", 96'(bus_a.rd_valid), 96'(0));
    chk("empty_b", 96'(bus_b.rd_valid), 96'(0));
    arm = 1; step(); arm = 0;
    chk("rearm_b", 96'(state_b), 96'(1));
    chk("rearm_ovf_b", 96'(ovf_b), 96'(0));

    // Full FIFO with simultaneous push and pop on B.
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1; instr = 32'h3000_0000 + 32'(i);
      step();
    end
    chk("full_lvl_b", 96'(level_b), 96'(4));
    wb_valid = 1; instr = 32'h3000_0004; rdy = 1;
    step();
    wb_valid = 0;
    chk("pushpop_lvl_b", 96'(level_b), 96'(4));
    chk("pushpop_ovf_b", 96'(ovf_b), 96'(0));
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("order_b%0d", j), 96'(bus_b.rd_data[63:0]), 96'(ent(32'h3000_0001 + 32'(j))));
      step();
    end
    rdy = 0;
    chk("order_empty_b", 96'(bus_b.rd_valid), 96'(0));

    // Asynchronous reset in the middle of a capture.
    wb_valid = 1; instr = 32'h4000_0000; step(); wb_valid = 0;
    chk("pre_rst_lvl", 96'(level_a), 96'(1));
    rst = 1; #1;
    chk("mid_rst_state_a", 96'(state_a), 96'(0));
    chk("mid_rst_state_b", 96'(state_b), 96'(0));
    chk("mid_rst_level", 96'(level_a), 96'(0));
    chk("mid_rst_valid", 96'(bus_a.rd_valid), 96'(0));
    chk("mid_rst_data", 96'(bus_a.rd_data), 96'(0));
    chk("mid_rst_ovf", 96'(ovf_b), 96'(0));
    step();
    rst = 0;

`ifdef TRACE_TIMESTAMP_EN
    // Timestamp counts edges since reset release: edge k samples k-1.
    mode = 0; arm = 1; step(); arm = 0;
    step(); step();
    wb_valid = 1; instr = 32'h5000_0003; step(); wb_valid = 0;
    step();
    wb_valid = 1; instr = 32'h5000_0005; step(); wb_valid = 0;
    chk("ts_first", 96'(bus_a.rd_data[DW-1:64]), 96'(3));
    rdy = 1; step(); rdy = 0;
    chk("ts_second", 96'(bus_a.rd_data[DW-1:64]), 96'(5));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
